// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song playback controller: FSM state encoding,
// bus widths, default sizing and the "no song selected" code.
package song_sequencer_pkg;

  localparam int SONG_LEN_DEF   = 26;
  localparam int GAP_CYCLES_DEF = 5000000;
  localparam int DUR_W_DEF      = 26;

  localparam int NOTE_W = 4;
  localparam int LOC_W  = 5;
  localparam int SONG_W = 2;

  localparam logic [SONG_W-1:0] SONG_NONE = 2'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_PLAY,
    ST_GAP
  } state_t;

endpackage

// File: rtl/song_sequencer_if.sv
// Song memory bus. The sequencer is the master: it drives read enable, song
// number and slot location; the memory (slave) returns note, duration and a
// valid flag one cycle after a read is presented.
interface song_sequencer_if
  import song_sequencer_pkg::*;
#(
  parameter int DUR_W = DUR_W_DEF
);
  logic              mem_isread;
  logic [SONG_W-1:0] mem_songnum;
  logic [LOC_W-1:0]  mem_location;
  logic [NOTE_W-1:0] mem_note;
  logic [DUR_W-1:0]  mem_duration;
  logic              mem_isvalid;

  modport master (
    output mem_isread, mem_songnum, mem_location,
    input  mem_note, mem_duration, mem_isvalid
  );

  modport slave (
    input  mem_isread, mem_songnum, mem_location,
    output mem_note, mem_duration, mem_isvalid
  );
endinterface

// File: rtl/song_sequencer_dur_counter.sv
// Down-counter shared by note duration and inter-note gap timing.
// Ports: clk, rst (async, active-high); i_load/i_load_val load a new count
// (load wins over enable); i_en decrements by one while nonzero;
// o_zero flags a count of 0.
module song_sequencer_dur_counter #(
  parameter int DUR_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [DUR_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [DUR_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/song_sequencer.sv
// Playback controller upstream of the song memory. Fetches each slot of the
// selected song, sounds the returned note for its duration, then inserts a
// fixed silent gap. Supports pause, stop, looping and reports invalid data.
// Ports: clk, rst (async, active-high); start/stop/pause/loop_en levels;
// song_sel request (0 = none); mem memory bus (master side); note_out and
// note_active to the tone generator; playing, cur_location, song_done and
// sticky err to the UI.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int SONG_LEN   = SONG_LEN_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int DUR_W      = DUR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               loop_en,
  input  logic [SONG_W-1:0]  song_sel,
  song_sequencer_if.master   mem,
  output logic [NOTE_W-1:0]  note_out,
  output logic               note_active,
  output logic               playing,
  output logic [LOC_W-1:0]   cur_location,
  output logic               song_done,
  output logic               err
);

  localparam logic [LOC_W-1:0] LAST_IDX = LOC_W'(SONG_LEN - 1);
  localparam logic [DUR_W-1:0] GAP_LOAD = DUR_W'(GAP_CYCLES - 1);

  state_t            r_state;
  logic [SONG_W-1:0] r_song;
  logic [LOC_W-1:0]  r_idx;
  logic [NOTE_W-1:0] r_note;
  logic              r_isread;
  logic              r_done;
  logic              r_err;

  logic              w_load;
  logic [DUR_W-1:0]  w_load_val;
  logic              w_cnt_en;
  logic              w_zero;

  // Counter control: WAIT loads the note length (or straight to the gap for a
  // zero-duration slot), PLAY expiry loads the gap, stop clears it.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    if (stop) begin
      w_load = 1'b1;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (mem.mem_isvalid) begin
            w_load     = 1'b1;
            w_load_val = (mem.mem_duration == '0) ? GAP_LOAD
                                                   : mem.mem_duration - 1'b1;
          end
        end
        ST_PLAY: begin
          if (!pause && w_zero) begin
            w_load     = 1'b1;
            w_load_val = GAP_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_cnt_en = ~pause & ((r_state == ST_PLAY) | (r_state == ST_GAP));

  song_sequencer_dur_counter #(.DUR_W(DUR_W)) u_dur_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_cnt_en),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_song   <= SONG_NONE;
      r_idx    <= '0;
      r_note   <= '0;
      r_isread <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop) begin
        r_state  <= ST_IDLE;
        r_note   <= '0;
        r_isread <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && (song_sel != SONG_NONE)) begin
              r_song   <= song_sel;
              r_idx    <= '0;
              r_err    <= 1'b0;
              r_isread <= 1'b1;
              r_state  <= ST_FETCH;
            end
          end
          // Read stays asserted through WAIT so the registered memory output
          // is still valid when sampled.
          ST_FETCH: r_state <= ST_WAIT;
          ST_WAIT: begin
            r_isread <= 1'b0;
            if (!mem.mem_isvalid) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else if (mem.mem_duration == '0) begin
              r_state <= ST_GAP;
            end else begin
              r_note  <= mem.mem_note;
              r_state <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (!pause && w_zero) r_state <= ST_GAP;
          end
          ST_GAP: begin
            if (!pause && w_zero) begin
              if (r_idx != LAST_IDX) begin
                r_idx    <= r_idx + 1'b1;
                r_isread <= 1'b1;
                r_state  <= ST_FETCH;
              end else if (loop_en) begin
                r_idx    <= '0;
                r_isread <= 1'b1;
                r_state  <= ST_FETCH;
              end else begin
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Address lines follow the latched song and slot index, so they hold their
  // last value whenever no read is in progress.
  assign mem.mem_isread   = r_isread;
  assign mem.mem_songnum  = r_song;
  assign mem.mem_location = r_idx;

  // Pause silences the note in the same cycle the counter freezes, keeping
  // sounded cycles equal to counted cycles.
  assign note_active  = (r_state == ST_PLAY) & ~pause;
  assign note_out     = r_note;
  assign playing      = (r_state != ST_IDLE);
  assign cur_location = r_idx;
  assign song_done    = r_done;
  assign err          = r_err;

endmodule
